// File: rtl/prime_test_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prime_test_pkg
// Description : Shared state encoding and defaults for the prime_test block.
// Revision    : 1.0 - initial release
// ============================================================================
package prime_test_pkg;

  // Default operand width selector: W = 1 << WIDTH_LOG.
  localparam int unsigned WIDTH_LOG_DEF = 4;

  // Controller states. DONE writes the outputs and returns to IDLE.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SMALL     = 3'd1,
    ST_DIV_START = 3'd2,
    ST_DIV_WAIT  = 3'd3,
    ST_NEXT      = 3'd4,
    ST_DONE      = 3'd5
  } state_e;

endpackage : prime_test_pkg
`default_nettype wire

// File: rtl/prime_test_divmod.sv
`default_nettype none
// ============================================================================
// Module      : prime_test_divmod
// Description : Restoring divider, one quotient bit per cycle, W iterations.
//               Only the remainder is exported; done pulses for one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module prime_test_divmod
  import prime_test_pkg::*;
#(
  parameter int WIDTH_LOG = WIDTH_LOG_DEF,
  localparam int W = 1 << WIDTH_LOG
) (
  input  logic         clk,
  input  logic         rst,     // asynchronous, active-low
  input  logic         start,   // accepted only while idle
  input  logic [W-1:0] a,       // dividend
  input  logic [W-1:0] b,       // divisor (non-zero)
  output logic         done,    // one-cycle pulse, rem valid from here on
  output logic [W-1:0] rem
);

  localparam logic [WIDTH_LOG:0] ITERS = W[WIDTH_LOG:0];
  localparam logic [WIDTH_LOG:0] ONE   = {{WIDTH_LOG{1'b0}}, 1'b1};

  logic               busy_q;
  logic               done_q;
  logic [WIDTH_LOG:0] cnt_q;
  logic [W-1:0]       rem_q;
  logic [W-1:0]       quo_q;
  logic [W-1:0]       div_q;

  logic [W:0]         shl;
  logic               fits;
  logic [W-1:0]       rem_step;
  logic [W-1:0]       quo_step;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // When it fits, the difference is below the divisor, so the low W bits of
  // the wrapped subtraction are exact.
  always_comb begin
    shl      = {rem_q, quo_q[W-1]};
    fits     = (shl >= {1'b0, div_q});
    rem_step = fits ? (shl[W-1:0] - div_q) : shl[W-1:0];
    quo_step = {quo_q[W-2:0], fits};
  end

  // Load on start when idle, then iterate W times and pulse done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      div_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (!busy_q) begin
        if (start) begin
          busy_q <= 1'b1;
          cnt_q  <= ITERS;
          rem_q  <= '0;
          quo_q  <= a;
          div_q  <= b;
        end
      end else begin
        rem_q <= rem_step;
        quo_q <= quo_step;
        cnt_q <= cnt_q - ONE;
        if (cnt_q == ONE) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done = done_q;
  assign rem  = rem_q;

endmodule : prime_test_divmod
`default_nettype wire

// File: rtl/prime_test.sv
`default_nettype none
// ============================================================================
// Module      : prime_test
// Description : Trial-division primality tester on a go/ready/error
//               handshake. Reports is_prime and the smallest factor > 1.
// Revision    : 1.0 - initial release
// ============================================================================
module prime_test
  import prime_test_pkg::*;
#(
  parameter int WIDTH_LOG = WIDTH_LOG_DEF,
  localparam int W = 1 << WIDTH_LOG
) (
  input  logic         clk,
  input  logic         rst,       // asynchronous, active-low
  input  logic         go,
  input  logic [W-1:0] n,
  output logic         ready,
  output logic         error,
  output logic         is_prime,
  output logic [W-1:0] factor
);

  localparam logic [W-1:0]   C_THREE  = W'(3);
  localparam logic [W-1:0]   C_TWO    = W'(2);
  localparam logic [W-1:0]   C_NINE   = W'(9);
  localparam logic [2*W-1:0] C_SQ9    = (2*W)'(9);
  localparam logic [2*W-1:0] C_SQ_INC = (2*W)'(4);

  state_e         state_q, state_d;
  logic [W-1:0]   n_q, n_d;
  logic [W-1:0]   d_q, d_d;          // current trial divisor
  logic [2*W-1:0] sq_q, sq_d;        // d*d, wide enough never to wrap
  logic           ready_q, ready_d;
  logic           error_q, error_d;
  logic           is_prime_q, is_prime_d;
  logic [W-1:0]   factor_q, factor_d;
  logic           res_prime_q, res_prime_d;    // verdict pending DONE
  logic [W-1:0]   res_factor_q, res_factor_d;

  logic           div_start;
  logic           div_done;
  logic [W-1:0]   div_rem;
  logic [2*W-1:0] sq_next;

  prime_test_divmod #(.WIDTH_LOG(WIDTH_LOG)) u_divmod (
    .clk   (clk),
    .rst   (rst),
    .start (div_start),
    .a     (n_q),
    .b     (d_q),
    .done  (div_done),
    .rem   (div_rem)
  );

  // (d+2)^2 = d^2 + 4d + 4, so the square tracks d without a multiplier.
  assign sq_next = sq_q + {{(W-2){1'b0}}, d_q, 2'b00} + C_SQ_INC;

  // Next-state, handshake and result logic.
  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    d_d          = d_q;
    sq_d         = sq_q;
    ready_d      = ready_q;
    error_d      = error_q;
    is_prime_d   = is_prime_q;
    factor_d     = factor_q;
    res_prime_d  = res_prime_q;
    res_factor_d = res_factor_q;
    div_start    = 1'b0;

    // A request while busy is dropped and flagged until reset.
    if (go && !ready_q) begin
      error_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (go && ready_q) begin
          n_d     = n;
          ready_d = 1'b0;
          state_d = ST_SMALL;
        end
      end

      ST_SMALL: begin
        if (n_q[W-1:1] == '0) begin            // 0 or 1
          res_prime_d  = 1'b0;
          res_factor_d = '0;
          state_d      = ST_DONE;
        end else if (n_q[W-1:2] == '0) begin   // 2 or 3
          res_prime_d  = 1'b1;
          res_factor_d = n_q;
          state_d      = ST_DONE;
        end else if (!n_q[0]) begin
          res_prime_d  = 1'b0;
          res_factor_d = C_TWO;
          state_d      = ST_DONE;
        end else begin
          d_d  = C_THREE;
          sq_d = C_SQ9;
          if (n_q < C_NINE) begin              // odd 5 or 7
            res_prime_d  = 1'b1;
            res_factor_d = n_q;
            state_d      = ST_DONE;
          end else begin
            state_d = ST_DIV_START;
          end
        end
      end

      ST_DIV_START: begin
        div_start = 1'b1;
        state_d   = ST_DIV_WAIT;
      end

      ST_DIV_WAIT: begin
        if (div_done) begin
          if (div_rem == '0) begin
            res_prime_d  = 1'b0;
            res_factor_d = d_q;
            state_d      = ST_DONE;
          end else begin
            state_d = ST_NEXT;
          end
        end
      end

      ST_NEXT: begin
        sq_d = sq_next;
        d_d  = d_q + C_TWO;
        if (sq_next > {{W{1'b0}}, n_q}) begin
          res_prime_d  = 1'b1;
          res_factor_d = n_q;
          state_d      = ST_DONE;
        end else begin
          state_d = ST_DIV_START;
        end
      end

      ST_DONE: begin
        is_prime_d = res_prime_q;
        factor_d   = res_factor_q;
        ready_d    = 1'b1;
        state_d    = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // State register; reset abandons any division in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      n_q          <= '0;
      d_q          <= '0;
      sq_q         <= '0;
      ready_q      <= 1'b1;
      error_q      <= 1'b0;
      is_prime_q   <= 1'b0;
      factor_q     <= '0;
      res_prime_q  <= 1'b0;
      res_factor_q <= '0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      d_q          <= d_d;
      sq_q         <= sq_d;
      ready_q      <= ready_d;
      error_q      <= error_d;
      is_prime_q   <= is_prime_d;
      factor_q     <= factor_d;
      res_prime_q  <= res_prime_d;
      res_factor_q <= res_factor_d;
    end
  end

  assign ready    = ready_q;
  assign error    = error_q;
  assign is_prime = is_prime_q;
  assign factor   = factor_q;

endmodule : prime_test
`default_nettype wire

// File: tb/tb_prime_test.sv
`default_nettype none
// ============================================================================
// Module      : tb_prime_test
// Description : Directed self-checking bench for prime_test (WIDTH_LOG=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prime_test;

  localparam int WL = 4;
  localparam int W  = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         go  = 1'b0;
  logic [W-1:0] n   = '0;
  logic         ready;
  logic         error;
  logic         is_prime;
  logic [W-1:0] factor;

  int checks   = 0;
  int failures = 0;

  logic rdy_prev = 1'b1;
  logic pending  = 1'b0;

  prime_test #(.WIDTH_LOG(WL)) dut (
    .clk      (clk),
    .rst      (rst),
    .go       (go),
    .n        (n),
    .ready    (ready),
    .error    (error),
    .is_prime (is_prime),
    .factor   (factor)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: smallest divisor > 1, n itself if prime, 0 below 2.
  function automatic int ref_factor(input int v);
    if (v < 2) return 0;
    for (int d = 2; d * d <= v; d++) begin
      if (v % d == 0) return d;
    end
    return v;
  endfunction

  // Issue one request and check results; latency counts the accept edge
  // through the edge on which ready rises. exp_lat <= 0 skips that check.
  task automatic run(input int val, input int exp_p, input int exp_f,
                     input int exp_lat, input string tag);
    int lat;
    @(negedge clk);
    go = 1'b1;
    n  = val[W-1:0];
    @(negedge clk);
    go  = 1'b0;
    lat = 1;
    while (ready !== 1'b1 && lat < 5000) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "/ready"}, 32'(ready), 32'd1);
    if (exp_lat > 0) chk({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "/is_prime"}, 32'(is_prime), 32'(exp_p));
    chk({tag, "/factor"}, 32'(factor), 32'(exp_f));
  endtask

  // ready may only rise after an accepted go (pre-edge values at posedge).
  always @(posedge clk) begin
    if (!rst) begin
      rdy_prev <= 1'b1;
      pending  <= 1'b0;
    end else begin
      if (!rdy_prev && ready === 1'b1) begin
        chk("rise_after_go", 32'(pending), 32'd1);
        pending <= go && ready;
      end else if (go && ready) begin
        pending <= 1'b1;
      end
      rdy_prev <= ready;
    end
  end

  initial begin
    int v;
    int ef;
    int waited;

    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("reset/ready", 32'(ready), 32'd1);
    chk("reset/error", 32'(error), 32'd0);
    chk("reset/is_prime", 32'(is_prime), 32'd0);
    chk("reset/factor", 32'(factor), 32'd0);

    run(97, 1, 97, 79, "n97");
    run(91, 0, 7, 0, "n91");
    run(1, 0, 0, 3, "n1");
    run(2, 1, 2, 3, "n2");
    run(3, 1, 3, 3, "n3");
    run(0, 0, 0, 3, "n0");
    run(4, 0, 2, 3, "n4");
    run(5, 1, 5, 3, "n5");
    run(9, 0, 3, 0, "n9");
    run(25, 0, 5, 0, "n25");
    run(49, 0, 7, 0, "n49");
    run(65535, 0, 3, 0, "n65535");
    run(65521, 1, 65521, 2416, "n65521");

    // Results held while idle with go low.
    repeat (20) @(negedge clk);
    chk("hold/ready", 32'(ready), 32'd1);
    chk("hold/is_prime", 32'(is_prime), 32'd1);
    chk("hold/factor", 32'(factor), 32'd65521);

    for (int i = 0; i < 150; i++) begin
      v  = int'($urandom_range(0, 2047));
      ef = ref_factor(v);
      run(v, (v >= 2 && ef == v) ? 1 : 0, ef, 0, "rand");
    end
    chk("pre_err/error", 32'(error), 32'd0);

    // go while busy: flagged, ignored, running test unaffected.
    @(negedge clk);
    go = 1'b1;
    n  = 16'd91;
    @(negedge clk);
    go = 1'b0;
    repeat (10) @(negedge clk);
    go = 1'b1;
    n  = 16'd5;
    @(negedge clk);
    go = 1'b0;
    chk("busy_go/error", 32'(error), 32'd1);
    waited = 0;
    while (ready !== 1'b1 && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    chk("busy_go/ready", 32'(ready), 32'd1);
    chk("busy_go/is_prime", 32'(is_prime), 32'd0);
    chk("busy_go/factor", 32'(factor), 32'd7);
    repeat (5) @(negedge clk);
    chk("busy_go/error_sticky", 32'(error), 32'd1);

    // Asynchronous reset mid-division.
    @(negedge clk);
    go = 1'b1;
    n  = 16'd65521;
    @(negedge clk);
    go = 1'b0;
    repeat (100) @(negedge clk);
    chk("mid/busy", 32'(ready), 32'd0);
    rst = 1'b0;
    #2;
    chk("mid_rst/ready", 32'(ready), 32'd1);
    chk("mid_rst/error", 32'(error), 32'd0);
    chk("mid_rst/is_prime", 32'(is_prime), 32'd0);
    chk("mid_rst/factor", 32'(factor), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run(9, 0, 3, 0, "post_rst_n9");
    chk("post_rst/error", 32'(error), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_prime_test
`default_nettype wire
